// File: rtl/seq_cmp_pkg.sv
// Shared types and result encodings for the sequential magnitude comparator.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Same one-hot encoding as the 4-bit combinational comparator: {gt, eq, lt}.
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/slice_cmp.sv
// Combinational SLICE-bit magnitude comparator; with sgn set the MSB is a
// two's-complement sign bit, so flipping it turns signed order into unsigned order.
module slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             sgn,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [SLICE-1:0] flip;
  logic [SLICE-1:0] xk;
  logic [SLICE-1:0] yk;

  assign flip = SLICE'(sgn) << (SLICE - 1);
  assign xk   = x ^ flip;
  assign yk   = y ^ flip;

  assign gt = (xk > yk);
  assign eq = (xk == yk);
  assign lt = (xk < yk);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator, MSB slice first with early exit.
// Define SEQ_CMP_SIGNED_EN to add the signed_mode port (two's-complement compare).
module seq_mag_comp
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4   // WIDTH must be a multiple of SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [2:0]       q
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  state_t           state;
  state_t           state_nx;
  logic             load;
  logic             finish;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic             top_sgn;
  logic             s_gt;
  logic             s_eq;
  logic             s_lt;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!s_eq || idx == '0) begin
          finish   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      q   <= CMP_NONE;
    end else if (load) begin
      a_r <= a;
      b_r <= b;
      idx <= IDX_TOP;
    end else if (state == ST_RUN) begin
      if (finish) q <= s_gt ? CMP_GT : (s_lt ? CMP_LT : CMP_EQ);
      else        idx <= idx - IDXW'(1);
    end
  end

`ifdef SEQ_CMP_SIGNED_EN
  logic sgn_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sgn_r <= 1'b0;
    else if (load) sgn_r <= signed_mode;
  end

  // Only the top slice carries the sign; lower slices stay unsigned.
  assign top_sgn = sgn_r && (idx == IDX_TOP);
`else
  assign top_sgn = 1'b0;
`endif

  assign sa = SLICE'(a_r >> (idx * SLICE));
  assign sb = SLICE'(b_r >> (idx * SLICE));

  slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .x   (sa),
    .y   (sb),
    .sgn (top_sgn),
    .gt  (s_gt),
    .eq  (s_eq),
    .lt  (s_lt)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_mag_comp.sv
// Scoreboard bench for seq_mag_comp: a 16/4 instance on directed vectors and a
// 4/4 instance swept over all operand pairs.
module tb_seq_mag_comp;
  import seq_cmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sm;
  logic        busy;
  logic        done;
  logic [2:0]  q;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [2:0]  q4;

  always #5 clk = ~clk;

  seq_mag_comp #(.WIDTH(16), .SLICE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef SEQ_CMP_SIGNED_EN
    .signed_mode (sm),
`endif
    .busy        (busy),
    .done        (done),
    .q           (q)
  );

  seq_mag_comp #(.WIDTH(4), .SLICE(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .a           (a4),
    .b           (b4),
`ifdef SEQ_CMP_SIGNED_EN
    .signed_mode (1'b0),
`endif
    .busy        (busy4),
    .done        (done4),
    .q           (q4)
  );

  typedef struct {
    logic [2:0] res;
    int         cyc;
    int         m;
  } exp_t;

  exp_t sb16[$];
  exp_t sb4[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;
  int   busy_run4 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop the oldest expectation whenever a done pulse appears.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut16 unexpected done: got q=%b with empty scoreboard", q);
        end else begin
          e = sb16.pop_front();
          check("dut16 q", 32'(q), 32'(e.res));
          check("dut16 done latency", cyc, e.cyc);
          check("dut16 busy cycles", busy_run, e.m);
        end
        busy_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run4 = 0;
    end else begin
      if (busy4) busy_run4++;
      if (done4) begin
        if (sb4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut4 unexpected done: got q=%b with empty scoreboard", q4);
        end else begin
          e = sb4.pop_front();
          check("dut4 q", 32'(q4), 32'(e.res));
          check("dut4 done latency", cyc, e.cyc);
          check("dut4 busy cycles", busy_run4, e.m);
        end
        busy_run4 = 0;
      end
    end
  end

  // Drive one start pulse from the current negedge; m = slices examined.
  task automatic drive16(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         input int m, input logic [2:0] res);
    a     = va;
    b     = vb;
    sm    = vs;
    start = 1'b1;
    sb16.push_back('{res, cyc + 1 + m, m});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         input int m, input logic [2:0] res);
    @(negedge clk);
    drive16(va, vb, vs, m, res);
  endtask

  task automatic drain(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (sb16.size() == 0 && sb4.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: got %0d+%0d pending expected 0", sb16.size(), sb4.size());
      sb16.delete();
      sb4.delete();
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    a      = '0;
    b      = '0;
    a4     = '0;
    b4     = '0;
    sm     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset q", 32'(q), 32'(CMP_NONE));
    check("reset q4", 32'(q4), 32'(CMP_NONE));
    rst = 1'b0;

    // Directed vectors: {a, b, signed, slices examined, result}.
    issue16(16'h1234, 16'h1234, 1'b0, 4, CMP_EQ);  drain(20);
    issue16(16'h8000, 16'h7FFF, 1'b0, 1, CMP_GT);  drain(20);
    issue16(16'h1235, 16'h1234, 1'b0, 4, CMP_GT);  drain(20);
    issue16(16'h1204, 16'h1234, 1'b0, 3, CMP_LT);  drain(20);
    issue16(16'h0000, 16'h0001, 1'b0, 4, CMP_LT);  drain(20);
    issue16(16'hFFFF, 16'hFFFE, 1'b0, 4, CMP_GT);  drain(20);
    issue16(16'hA0F0, 16'hA1F0, 1'b0, 2, CMP_LT);  drain(20);
    issue16(16'h0000, 16'h0000, 1'b0, 4, CMP_EQ);  drain(20);
`ifdef SEQ_CMP_SIGNED_EN
    issue16(16'h8000, 16'h7FFF, 1'b1, 1, CMP_LT);  drain(20);
    issue16(16'hFFFF, 16'h0001, 1'b1, 1, CMP_LT);  drain(20);
    issue16(16'h7000, 16'h7001, 1'b1, 4, CMP_LT);  drain(20);
    issue16(16'h0123, 16'hF123, 1'b1, 1, CMP_GT);  drain(20);
`endif

    // Start during RUN is ignored, and operand changes do not disturb the result.
    issue16(16'h1235, 16'h1234, 1'b0, 4, CMP_GT);
    a     = 16'h0000;
    b     = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(20);

    // Start in the DONE cycle is accepted back-to-back.
    issue16(16'h2000, 16'h1000, 1'b0, 1, CMP_GT);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done seen before back-to-back start", 32'(done), 1);
    drive16(16'h5500, 16'h5501, 1'b0, 4, CMP_LT);
    drain(20);

    // Reset in the second RUN cycle kills the comparison with no done.
    issue16(16'h1234, 16'h1234, 1'b0, 4, CMP_EQ);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-run reset busy", 32'(busy), 0);
    check("mid-run reset done", 32'(done), 0);
    check("mid-run reset q", 32'(q), 32'(CMP_NONE));
    sb16.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post-reset q held", 32'(q), 32'(CMP_NONE));

    // WIDTH=SLICE=4: every pair resolves in one slice.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        a4     = 4'(i);
        b4     = 4'(j);
        start4 = 1'b1;
        sb4.push_back('{(i > j) ? CMP_GT : ((i == j) ? CMP_EQ : CMP_LT), cyc + 2, 1});
        @(negedge clk);
        start4 = 1'b0;
      end
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
